// File: rtl/usb_rx_packet_buffer.sv
// USB RX packet buffer: captures SYNC/PID, reports SYNC/PID/CRC checks and stages
// data payload in a FIFO that only exposes bytes of packets ending with a good CRC16.
module usb_rx_packet_buffer #(
    parameter int          DEPTH         = 64,
    parameter logic [7:0]  SYNC_PATTERN  = 8'h80,
    parameter logic [4:0]  CRC5_RESIDUE  = 5'b01100,
    parameter logic [15:0] CRC16_RESIDUE = 16'h0000,
    localparam int         CW            = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          byte_complete,
    input  logic [7:0]    Packet_Data,
    input  logic          load_sync,
    input  logic          load_pid,
    input  logic          load_data,
    input  logic          check_sync,
    input  logic          check_pid,
    input  logic          crc_check_5,
    input  logic          crc_check_16,
    input  logic [4:0]    crc_5bit,
    input  logic [15:0]   crc_16bit,
    input  logic          load_error,
    input  logic          load_done,
    input  logic          clear,
    input  logic          flush,
    input  logic          rx_data_read,
    output logic [1:0]    sync_status,
    output logic [2:0]    pid_status,
    output logic [1:0]    crc_status,
    output logic [2:0]    rx_packet,
    output logic [7:0]    rx_packet_data,
    output logic          rx_data_valid,
    output logic [CW-1:0] committed_count,
    output logic          buffer_full,
    output logic          overflow
);

    localparam int AW = CW - 1;

    typedef enum logic [2:0] {
        PKT_IDLE  = 3'd0,
        PKT_IN    = 3'd1,
        PKT_OUT   = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_ERROR = 3'd4,
        PKT_DONE  = 3'd5,
        PKT_NAK   = 3'd6,
        PKT_STALL = 3'd7
    } pkt_e;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    sync_byte_q, pid_q;
    logic [CW-1:0] rd_q, commit_q, wr_q;
    logic [CW-1:0] rd_d, commit_d, wr_d;
    logic          crc16_ok_q, crc16_ok_d;
    logic          overflow_q, overflow_d;
    pkt_e          pkt_q, pkt_d;

    logic          wr_en, wr_ok, drop, crc16_good, commit_ok, pid_load, pid_valid, rd_en;
    logic [CW-1:0] wr_after, pending_after;

    assign sync_status = !check_sync ? 2'b00 :
                         (sync_byte_q == SYNC_PATTERN) ? 2'b01 : 2'b10;

    always_comb begin
        pid_status = 3'b000;
        if (check_pid) begin
            if (pid_q[3:0] != ~pid_q[7:4]) begin
                pid_status = 3'b100;
            end else begin
                case (pid_q[3:0])
                    4'b0001, 4'b1001:          pid_status = 3'b001;
                    4'b0011, 4'b1011:          pid_status = 3'b010;
                    4'b0010, 4'b1010, 4'b1110: pid_status = 3'b011;
                    default:                   pid_status = 3'b000;
                endcase
            end
        end
    end

    always_comb begin
        crc_status = 2'b00;
        if (crc_check_5) begin
            crc_status = (crc_5bit == CRC5_RESIDUE) ? 2'b01 : 2'b10;
        end else if (crc_check_16) begin
            if (crc_16bit == CRC16_RESIDUE)   crc_status = 2'b01;
            else if (crc_16bit == 16'hFFFF)   crc_status = 2'b00;
            else                              crc_status = 2'b10;
        end
    end

    assign committed_count = commit_q - rd_q;
    assign rx_data_valid   = (committed_count != '0);
    assign buffer_full     = ((wr_q - rd_q) == CW'(DEPTH));
    assign rx_packet_data  = mem[rd_q[AW-1:0]];
    assign overflow        = overflow_q;
    assign rx_packet       = pkt_q;

    // A byte arriving alongside load_done counts toward the commit decision.
    assign wr_en         = byte_complete & load_data;
    assign wr_ok         = wr_en & ~buffer_full;
    assign drop          = wr_en & buffer_full;
    assign wr_after      = wr_ok ? wr_q + 1'b1 : wr_q;
    assign pending_after = wr_after - commit_q;
    assign crc16_good    = crc_check_16 & ~crc_check_5 & (crc_16bit == CRC16_RESIDUE);
    assign commit_ok     = (crc16_ok_q | crc16_good) & ~(overflow_q | drop) &
                           (pending_after >= CW'(2));
    assign pid_load      = byte_complete & load_pid;
    assign pid_valid     = (Packet_Data[3:0] == ~Packet_Data[7:4]);
    assign rd_en         = rx_data_read & rx_data_valid;

    always_comb begin
        rd_d       = rd_en ? rd_q + 1'b1 : rd_q;
        commit_d   = commit_q;
        wr_d       = wr_after;
        overflow_d = overflow_q | drop;
        crc16_ok_d = crc16_ok_q | crc16_good;
        pkt_d      = pkt_q;
        if (pid_load) begin
            overflow_d = 1'b0;
            crc16_ok_d = 1'b0;
        end
        if (flush) begin
            rd_d       = '0;
            commit_d   = '0;
            wr_d       = '0;
            overflow_d = 1'b0;
            pkt_d      = PKT_IDLE;
        end else if (clear) begin
            wr_d  = commit_q;
            pkt_d = PKT_IDLE;
        end else if (load_done) begin
            // Trailing two bytes are the CRC16 and never become readable.
            if (commit_ok) begin
                commit_d = wr_after - CW'(2);
                wr_d     = wr_after - CW'(2);
                pkt_d    = PKT_DONE;
            end else begin
                wr_d  = commit_q;
                pkt_d = (pending_after != '0) ? PKT_ERROR : PKT_DONE;
            end
        end else if (load_error) begin
            wr_d  = commit_q;
            pkt_d = PKT_ERROR;
        end else if (pid_load && pid_valid) begin
            case (Packet_Data[3:0])
                4'b1001: pkt_d = PKT_IN;
                4'b0001: pkt_d = PKT_OUT;
                4'b0010: pkt_d = PKT_ACK;
                4'b1010: pkt_d = PKT_NAK;
                4'b1110: pkt_d = PKT_STALL;
                default: pkt_d = pkt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_byte_q <= '0;
            pid_q       <= '0;
            rd_q        <= '0;
            commit_q    <= '0;
            wr_q        <= '0;
            crc16_ok_q  <= 1'b0;
            overflow_q  <= 1'b0;
            pkt_q       <= PKT_IDLE;
        end else begin
            if (byte_complete && load_sync) sync_byte_q <= Packet_Data;
            if (pid_load)                   pid_q       <= Packet_Data;
            rd_q       <= rd_d;
            commit_q   <= commit_d;
            wr_q       <= wr_d;
            crc16_ok_q <= crc16_ok_d;
            overflow_q <= overflow_d;
            pkt_q      <= pkt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_q[AW-1:0]] <= Packet_Data;
    end

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// Bench for usb_rx_packet_buffer: status vector table, directed packet sequences on an
// 8-deep and a 4-deep instance, then random traffic against a queue-based model.
module tb_usb_rx_packet_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, byte_complete, load_sync, load_pid, load_data;
    logic        check_sync, check_pid, crc_check_5, crc_check_16;
    logic        load_error, load_done, clear, flush, rx_data_read;
    logic [7:0]  Packet_Data;
    logic [4:0]  crc_5bit;
    logic [15:0] crc_16bit;

    logic [1:0] ss_a, cs_a, ss_b, cs_b;
    logic [2:0] ps_a, rx_a, ps_b, rx_b;
    logic [7:0] hd_a, hd_b;
    logic       vld_a, full_a, ov_a, vld_b, full_b, ov_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;

    usb_rx_packet_buffer #(.DEPTH(8)) dut_a (
        .clk(clk), .n_rst(n_rst), .byte_complete(byte_complete), .Packet_Data(Packet_Data),
        .load_sync(load_sync), .load_pid(load_pid), .load_data(load_data),
        .check_sync(check_sync), .check_pid(check_pid), .crc_check_5(crc_check_5),
        .crc_check_16(crc_check_16), .crc_5bit(crc_5bit), .crc_16bit(crc_16bit),
        .load_error(load_error), .load_done(load_done), .clear(clear), .flush(flush),
        .rx_data_read(rx_data_read), .sync_status(ss_a), .pid_status(ps_a),
        .crc_status(cs_a), .rx_packet(rx_a), .rx_packet_data(hd_a), .rx_data_valid(vld_a),
        .committed_count(cnt_a), .buffer_full(full_a), .overflow(ov_a));

    usb_rx_packet_buffer #(.DEPTH(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .byte_complete(byte_complete), .Packet_Data(Packet_Data),
        .load_sync(load_sync), .load_pid(load_pid), .load_data(load_data),
        .check_sync(check_sync), .check_pid(check_pid), .crc_check_5(crc_check_5),
        .crc_check_16(crc_check_16), .crc_5bit(crc_5bit), .crc_16bit(crc_16bit),
        .load_error(load_error), .load_done(load_done), .clear(clear), .flush(flush),
        .rx_data_read(rx_data_read), .sync_status(ss_b), .pid_status(ps_b),
        .crc_status(cs_b), .rx_packet(rx_b), .rx_packet_data(hd_b), .rx_data_valid(vld_b),
        .committed_count(cnt_b), .buffer_full(full_b), .overflow(ov_b));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        byte_complete = 0; load_sync = 0; load_pid = 0; load_data = 0;
        check_sync = 0; check_pid = 0; crc_check_5 = 0; crc_check_16 = 0;
        load_error = 0; load_done = 0; clear = 0; flush = 0; rx_data_read = 0;
        Packet_Data = 8'h00; crc_5bit = 5'h00; crc_16bit = 16'h0000;
    endtask

    // kind: 0 SYNC, 1 PID, 2 payload
    task automatic send(input int kind, input logic [7:0] d);
        byte_complete = 1; Packet_Data = d;
        load_sync = (kind == 0); load_pid = (kind == 1); load_data = (kind == 2);
        tick();
        byte_complete = 0; load_sync = 0; load_pid = 0; load_data = 0;
    endtask

    task automatic good_crc();
        crc_check_16 = 1; crc_16bit = 16'h0000;
        tick();
        crc_check_16 = 0;
    endtask

    task automatic done();
        load_done = 1;
        tick();
        load_done = 0;
    endtask

    // Reference behaviour derived from the packet rules
    function automatic logic [1:0] e_sync(input logic cs, input logic [7:0] sb);
        if (!cs) return 2'd0;
        return (sb == 8'h80) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [2:0] e_pid(input logic cp, input logic [7:0] p);
        if (!cp) return 3'd0;
        if (p[3:0] != ~p[7:4]) return 3'd4;
        if (p[3:0] == 4'h1 || p[3:0] == 4'h9) return 3'd1;
        if (p[3:0] == 4'h3 || p[3:0] == 4'hB) return 3'd2;
        if (p[3:0] == 4'h2 || p[3:0] == 4'hA || p[3:0] == 4'hE) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [1:0] e_crc(input logic c5, input logic c16,
                                         input logic [4:0] r5, input logic [15:0] r16);
        if (c5) return (r5 == 5'b01100) ? 2'd1 : 2'd2;
        if (c16) return (r16 == 16'h0000) ? 2'd1 : (r16 == 16'hFFFF) ? 2'd0 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [2:0] pid_pkt(input logic [7:0] p, input logic [2:0] cur);
        if (p[3:0] != ~p[7:4]) return cur;
        if (p[3:0] == 4'h9) return 3'd1;
        if (p[3:0] == 4'h1) return 3'd2;
        if (p[3:0] == 4'h2) return 3'd3;
        if (p[3:0] == 4'hA) return 3'd6;
        if (p[3:0] == 4'hE) return 3'd7;
        return cur;
    endfunction

    typedef struct {
        logic [7:0]  sb;
        logic [7:0]  pb;
        logic        cs, cp, c5, c16;
        logic [4:0]  r5;
        logic [15:0] r16;
        logic [1:0]  e_ss;
        logic [2:0]  e_ps;
        logic [1:0]  e_cs;
    } vec_t;

    vec_t vt [11];
    logic [7:0] pids [5];
    logic [2:0] pkts [5];

    logic [7:0] cq [$];
    logic [7:0] pq [$];
    logic       mov, mcrc;
    logic [2:0] mrx;
    logic [7:0] msync, mpid;

    initial begin
        vt[0]  = '{8'h80, 8'h69, 1, 1, 0, 0, 5'h00, 16'h0000, 2'd1, 3'd1, 2'd0};
        vt[1]  = '{8'h80, 8'h6A, 1, 1, 0, 0, 5'h00, 16'h0000, 2'd1, 3'd4, 2'd0};
        vt[2]  = '{8'h81, 8'hC3, 1, 1, 0, 0, 5'h00, 16'h0000, 2'd2, 3'd2, 2'd0};
        vt[3]  = '{8'h80, 8'hD2, 0, 1, 0, 0, 5'h00, 16'h0000, 2'd0, 3'd3, 2'd0};
        vt[4]  = '{8'h80, 8'hA5, 0, 1, 0, 0, 5'h00, 16'h0000, 2'd0, 3'd0, 2'd0};
        vt[5]  = '{8'h80, 8'hE1, 1, 1, 1, 0, 5'h0C, 16'h0000, 2'd1, 3'd1, 2'd1};
        vt[6]  = '{8'h80, 8'h4B, 0, 1, 1, 0, 5'h00, 16'h0000, 2'd0, 3'd2, 2'd2};
        vt[7]  = '{8'h80, 8'hC3, 0, 0, 0, 1, 5'h00, 16'hFFFF, 2'd0, 3'd0, 2'd0};
        vt[8]  = '{8'h80, 8'hC3, 0, 0, 0, 1, 5'h00, 16'h1234, 2'd0, 3'd0, 2'd2};
        vt[9]  = '{8'h80, 8'hC3, 0, 0, 1, 1, 5'h0C, 16'h1234, 2'd0, 3'd0, 2'd1};
        vt[10] = '{8'h80, 8'hC3, 0, 0, 0, 1, 5'h00, 16'h0000, 2'd0, 3'd0, 2'd1};
        pids = '{8'h69, 8'hE1, 8'hD2, 8'h5A, 8'h1E};
        pkts = '{3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        idle();
        n_rst = 0;
        tick(); tick();
        chk("reset rx_packet", 32'(rx_a), 32'd0);
        chk("reset count", 32'(cnt_a), 32'd0);
        chk("reset valid", 32'(vld_a), 32'd0);
        chk("reset full", 32'(full_a), 32'd0);
        chk("reset overflow", 32'(ov_a), 32'd0);
        chk("reset sync_status", 32'(ss_a), 32'd0);
        chk("reset pid_status", 32'(ps_a), 32'd0);
        chk("reset crc_status", 32'(cs_a), 32'd0);
        n_rst = 1;
        tick();

        for (int i = 0; i < 11; i++) begin
            send(0, vt[i].sb);
            send(1, vt[i].pb);
            check_sync = vt[i].cs; check_pid = vt[i].cp;
            crc_check_5 = vt[i].c5; crc_check_16 = vt[i].c16;
            crc_5bit = vt[i].r5; crc_16bit = vt[i].r16;
            #1;
            chk($sformatf("vec%0d sync_status", i), 32'(ss_a), 32'(vt[i].e_ss));
            chk($sformatf("vec%0d pid_status", i), 32'(ps_a), 32'(vt[i].e_ps));
            chk($sformatf("vec%0d crc_status", i), 32'(cs_a), 32'(vt[i].e_cs));
            tick();
            idle();
        end

        for (int i = 0; i < 5; i++) begin
            send(1, pids[i]);
            chk($sformatf("pid %0h rx_packet", pids[i]), 32'(rx_a), 32'(pkts[i]));
        end

        // DATA0 with good CRC16
        flush = 1; tick(); flush = 0;
        send(1, 8'hC3);
        send(2, 8'h11); send(2, 8'h22); send(2, 8'h33); send(2, 8'hAA); send(2, 8'hBB);
        chk("data pending count", 32'(cnt_a), 32'd0);
        crc_check_16 = 1; crc_16bit = 16'h0000;
        #1 chk("good crc16 status", 32'(cs_a), 32'd1);
        tick(); crc_check_16 = 0;
        done();
        chk("commit count", 32'(cnt_a), 32'd3);
        chk("commit rx_packet", 32'(rx_a), 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("read%0d head", i), 32'(hd_a), 32'(8'h11 * (i + 1)));
            rx_data_read = 1; tick(); rx_data_read = 0;
        end
        chk("drained valid", 32'(vld_a), 32'd0);
        rx_data_read = 1; tick(); rx_data_read = 0;
        chk("read while empty count", 32'(cnt_a), 32'd0);

        // DATA0 with bad CRC16
        send(1, 8'hC3);
        send(2, 8'h11); send(2, 8'h22); send(2, 8'h33); send(2, 8'hAA); send(2, 8'hBB);
        crc_check_16 = 1; crc_16bit = 16'h1234;
        #1 chk("bad crc16 status", 32'(cs_a), 32'd2);
        tick(); crc_check_16 = 0;
        done();
        chk("bad crc count", 32'(cnt_a), 32'd0);
        chk("bad crc rx_packet", 32'(rx_a), 32'd4);

        // Overflow on the 4-deep instance
        flush = 1; tick(); flush = 0;
        send(1, 8'hC3);
        for (int i = 1; i <= 4; i++) send(2, 8'(i));
        chk("d4 full", 32'(full_b), 32'd1);
        chk("d4 no overflow yet", 32'(ov_b), 32'd0);
        send(2, 8'h05);
        chk("d4 overflow", 32'(ov_b), 32'd1);
        send(2, 8'h06);
        good_crc();
        done();
        chk("d4 rollback count", 32'(cnt_b), 32'd0);
        chk("d4 rollback rx_packet", 32'(rx_b), 32'd4);
        chk("d4 rollback full", 32'(full_b), 32'd0);
        chk("d4 overflow sticky", 32'(ov_b), 32'd1);

        // Error and clear preserve committed data
        flush = 1; tick(); flush = 0;
        send(1, 8'hC3);
        send(2, 8'h11); send(2, 8'h22); send(2, 8'h33); send(2, 8'hAA); send(2, 8'hBB);
        good_crc();
        done();
        send(1, 8'hC3);
        send(2, 8'h44); send(2, 8'h55);
        load_error = 1; tick(); load_error = 0;
        chk("error rx_packet", 32'(rx_a), 32'd4);
        chk("error count kept", 32'(cnt_a), 32'd3);
        clear = 1; tick(); clear = 0;
        chk("clear rx_packet", 32'(rx_a), 32'd0);
        chk("clear count kept", 32'(cnt_a), 32'd3);
        chk("clear head kept", 32'(hd_a), 32'h11);

        // Last CRC byte, load_done and a read all in one cycle
        send(1, 8'hC3);
        send(2, 8'h66); send(2, 8'h77); send(2, 8'hAA);
        good_crc();
        byte_complete = 1; load_data = 1; Packet_Data = 8'hBB; load_done = 1; rx_data_read = 1;
        tick();
        idle();
        chk("read+commit count", 32'(cnt_a), 32'd4);
        chk("read+commit head", 32'(hd_a), 32'h22);
        begin
            logic [7:0] exp_rd [4];
            exp_rd = '{8'h22, 8'h33, 8'h66, 8'h77};
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("drain%0d", i), 32'(hd_a), 32'(exp_rd[i]));
                rx_data_read = 1; tick(); rx_data_read = 0;
            end
        end
        send(1, 8'hC3);
        send(2, 8'h01); send(2, 8'hAA); send(2, 8'hBB);
        good_crc();
        done();
        chk("pre-flush count", 32'(cnt_a), 32'd1);
        flush = 1; tick(); flush = 0;
        chk("flush count", 32'(cnt_a), 32'd0);
        chk("flush valid", 32'(vld_a), 32'd0);

        // Random traffic against the model
        clear = 1; tick(); clear = 0;
        send(0, 8'h80);
        send(1, 8'hC3);
        cq.delete(); pq.delete();
        mov = 0; mcrc = 0; mrx = 3'd0; msync = 8'h80; mpid = 8'hC3;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            logic [7:0] d;
            logic bc, ls, lp, ldt, ldn, le, cl, fl, rd, cs, cp, c5, c16;
            logic [4:0] r5;
            logic [15:0] r16;
            logic [7:0] plist [9];
            plist = '{8'h69, 8'hE1, 8'hD2, 8'h5A, 8'h1E, 8'hC3, 8'h4B, 8'hA5, 8'h00};
            plist[8] = 8'($urandom);
            r = int'($urandom_range(0, 99));
            d = 8'($urandom);
            ls = (r < 8); lp = (r >= 8 && r < 20); ldt = (r >= 20 && r < 62);
            ldn = (r >= 62 && r < 72); le = (r >= 72 && r < 76);
            cl = (r >= 76 && r < 78); fl = (r == 78);
            if (lp) d = plist[$urandom_range(0, 8)];
            if (ldn && $urandom_range(0, 9) < 3) ldt = 1;
            bc = ls | lp | ldt;
            rd = ($urandom_range(0, 9) < 4);
            cs = ($urandom_range(0, 9) < 3); cp = ($urandom_range(0, 9) < 3);
            c5 = ($urandom_range(0, 9) < 2); c16 = ($urandom_range(0, 9) < 3);
            r5 = ($urandom_range(0, 1) == 1) ? 5'b01100 : 5'($urandom);
            r = int'($urandom_range(0, 99));
            r16 = (r < 50) ? 16'h0000 : (r < 65) ? 16'hFFFF : 16'($urandom);

            byte_complete = bc; Packet_Data = d; load_sync = ls; load_pid = lp; load_data = ldt;
            load_done = ldn; load_error = le; clear = cl; flush = fl; rx_data_read = rd;
            check_sync = cs; check_pid = cp; crc_check_5 = c5; crc_check_16 = c16;
            crc_5bit = r5; crc_16bit = r16;
            #1;
            chk("rnd count", 32'(cnt_a), 32'(cq.size()));
            chk("rnd valid", 32'(vld_a), 32'(cq.size() > 0));
            if (cq.size() > 0) chk("rnd head", 32'(hd_a), 32'(cq[0]));
            chk("rnd full", 32'(full_a), 32'(cq.size() + pq.size() == 8));
            chk("rnd overflow", 32'(ov_a), 32'(mov));
            chk("rnd rx_packet", 32'(rx_a), 32'(mrx));
            chk("rnd sync_status", 32'(ss_a), 32'(e_sync(cs, msync)));
            chk("rnd pid_status", 32'(ps_a), 32'(e_pid(cp, mpid)));
            chk("rnd crc_status", 32'(cs_a), 32'(e_crc(c5, c16, r5, r16)));
            @(posedge clk);
            if (ls) msync = d;
            if (c16 && !c5 && r16 == 16'h0000) mcrc = 1;
            if (ldt) begin
                if (cq.size() + pq.size() == 8) mov = 1;
                else pq.push_back(d);
            end
            if (lp) begin mpid = d; mov = 0; mcrc = 0; end
            if (rd && cq.size() > 0) void'(cq.pop_front());
            if (fl) begin
                cq.delete(); pq.delete(); mov = 0; mrx = 3'd0;
            end else if (cl) begin
                pq.delete(); mrx = 3'd0;
            end else if (ldn) begin
                if (pq.size() == 0) mrx = 3'd5;
                else if (mcrc && !mov && pq.size() >= 2) begin
                    for (int k = 0; k < pq.size() - 2; k++) cq.push_back(pq[k]);
                    mrx = 3'd5;
                end else mrx = 3'd4;
                pq.delete();
            end else if (le) begin
                pq.delete(); mrx = 3'd4;
            end else if (lp) begin
                mrx = pid_pkt(d, mrx);
            end
            #1;
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
